// File: rtl/rotate_req_arbiter.sv
// rotate_req_arbiter
// Round-robin arbiter in front of a shared 4-bit rotate unit. The winning
// request is rotated and captured in a single result register, which is
// presented on a valid/ready response port tagged with the requester index.
// The register can reload on the same cycle it is drained, so a continuously
// ready consumer sees one result per cycle.

module rotate_req_arbiter #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [NREQ*4-1:0]   req_data_i,
  input  logic [NREQ*2-1:0]   req_shift_i,
  input  logic [NREQ-1:0]     req_dir_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [3:0]          rsp_data_o,
  output logic [ID_W-1:0]     rsp_id_o,
  output logic [CNT_W-1:0]    accept_cnt_o
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]        rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              gnt_found_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic [ID_W:0]     scan_sum_s;
  logic [ID_W-1:0]   scan_idx_s;
  logic [NREQ-1:0]   grant_s;
  logic              can_load_s;
  logic              transfer_s;
  logic [3:0]        operand_s;
  logic [1:0]        shift_s;
  logic              dir_s;
  logic [3:0]        rotated_s;

  // Rotate a nibble; a right rotate by s is a left rotate by (4 - s) mod 4.
  function automatic logic [3:0] rot4(input logic [3:0] d, input logic [1:0] s, input logic dir);
    logic [1:0] left_amt;
    left_amt = dir ? (2'd0 - s) : s;
    case (left_amt)
      2'd0:    rot4 = d;
      2'd1:    rot4 = {d[2:0], d[3]};
      2'd2:    rot4 = {d[1:0], d[3:2]};
      2'd3:    rot4 = {d[0], d[3:1]};
      default: rot4 = d;
    endcase
  endfunction

  // Scan requesters starting at rr_ptr and pick the first valid one.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_sum_s >= (ID_W+1)'(NREQ)) begin
        scan_sum_s = scan_sum_s - (ID_W+1)'(NREQ);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[ID_W-1:0];
      if (!gnt_found_s && req_valid_i[scan_idx_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = scan_idx_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // One-hot grant vector from the selected index.
  always_comb begin
    grant_s = '0;
    if (gnt_found_s) begin
      grant_s[gnt_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Only the granted lane is read, so junk on other lanes cannot leak out.
  assign operand_s = req_data_i[{gnt_idx_s, 2'b00} +: 4];
  assign shift_s   = req_shift_i[{gnt_idx_s, 1'b0} +: 2];
  assign dir_s     = req_dir_i[gnt_idx_s];
  assign rotated_s = rot4(operand_s, shift_s, dir_s);

  assign can_load_s = (state_q == EMPTY) | rsp_ready_i;
  assign transfer_s = gnt_found_s & can_load_s & ~rst_i;

  // Accept handshake: held low during reset and while the result is stalled.
  always_comb begin
    req_ready_o = '0;
    if (rst_i) begin
      req_ready_o = '0;
    end else begin
      req_ready_o = grant_s & {NREQ{can_load_s}};
    end
  end

  // Next-state for the result-register FSM, datapath and round-robin pointer.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    cnt_d      = cnt_q;

    case (state_q)
      EMPTY: begin
        if (transfer_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (rsp_ready_i && !transfer_s) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (transfer_s) begin
      rsp_data_d = rotated_s;
      rsp_id_d   = gnt_idx_s;
      if (gnt_idx_s == ID_W'(NREQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + ID_W'(1);
      end
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      rsp_data_d = rsp_data_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      rsp_data_q <= 4'd0;
      rsp_id_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rsp_valid_o  = (state_q == FULL);
  assign rsp_data_o   = rsp_data_q;
  assign rsp_id_o     = rsp_id_q;
  assign accept_cnt_o = cnt_q;

endmodule
